ftq_ctrl: RTL and testbench

//  Fetch target queue controller between the BPU/FTB and the icache. Buffers predicted

---
 rtl/ftq_ctrl_pkg.sv | 51 +++++
 rtl/ftq_ctrl_if.sv | 37 +++
 rtl/ftq_ctrl_ptr_ctrl.sv | 67 ++++++
 rtl/ftq_ctrl.sv | 116 +++++++++++
 tb/tb_ftq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ftq_ctrl_pkg.sv
// rtl/ftq_ctrl_pkg.sv - shared frontend types, sizes and helpers for the fetch target queue
package ftq_ctrl_pkg;

   localparam int XLEN               = 32;
   localparam int FTQ_SIZE_DEFAULT   = 8;
   localparam int FTQ_IDXW           = $clog2(FTQ_SIZE_DEFAULT);
   localparam int FTB_FALLTHRU_WIDTH = 12;
   localparam int FTB_PREDICT_WIDTH  = 5;

   typedef logic [FTQ_IDXW-1:0] ftqIdx_t;

   typedef enum logic {RUN, FLUSH} ftq_state_t;

   typedef struct packed {
      logic            hit_on_ftb;
      logic [1:0]      counter;
      logic [XLEN-1:0] target;
   } ftbInfo_t;

   typedef struct packed {
      logic [XLEN-1:0]               startAddr;
      logic [FTB_FALLTHRU_WIDTH:0]   endAddr;
      ftbInfo_t                      ftbInfo;
   } ftqInfo_t;

   typedef struct packed {
      logic [XLEN-1:0]              startAddr;
      logic [FTB_PREDICT_WIDTH-1:0] fetchBlock_size;
   } ftq2icacheInfo_t;

   typedef struct packed {
      logic [XLEN-1:0] startAddr;
      ftbInfo_t        ftb_update;
   } BPupdateInfo_t;

   function automatic logic [1:0] satCounterUpdate(input logic [1:0] cnt, input logic taken);
      if (taken)
         return (cnt == 2'b11) ? cnt : cnt + 2'b01;
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
   endfunction

   // endAddr is a truncated halfword address, so the subtraction wraps modulo its width
   function automatic ftq2icacheInfo_t toIcacheReq(input logic [XLEN-1:0] start_addr,
                                                   input logic [FTB_FALLTHRU_WIDTH:0] end_addr);
      ftq2icacheInfo_t r;
      r.startAddr       = start_addr;
      r.fetchBlock_size = FTB_PREDICT_WIDTH'(end_addr - start_addr[FTB_FALLTHRU_WIDTH+1:1]);
      return r;
   endfunction

endpackage

// File: rtl/ftq_ctrl_if.sv
// rtl/ftq_ctrl_if.sv - BPU, icache, commit and redirect handshakes of the fetch target queue
interface ftq_ctrl_if
   import ftq_ctrl_pkg::*;
();

   logic            bpu_enq_vld;
   ftqInfo_t        bpu_enq_info;
   logic            bpu_enq_rdy;
   logic            icache_req_vld;
   ftq2icacheInfo_t icache_req_info;
   ftqIdx_t         icache_req_ftqIdx;
   logic            icache_req_rdy;
   logic            commit_vld;
   logic            commit_taken;
   logic            bp_update_vld;
   BPupdateInfo_t   bp_update_info;
   logic            redirect_vld;
   ftqIdx_t         redirect_ftqIdx;
   logic [XLEN-1:0] redirect_pc;
   logic            bpu_redirect_vld;
   logic [XLEN-1:0] bpu_redirect_pc;

   modport master (
      output bpu_enq_vld, bpu_enq_info, icache_req_rdy, commit_vld, commit_taken,
             redirect_vld, redirect_ftqIdx, redirect_pc,
      input  bpu_enq_rdy, icache_req_vld, icache_req_info, icache_req_ftqIdx,
             bp_update_vld, bp_update_info, bpu_redirect_vld, bpu_redirect_pc
   );

   modport slave (
      input  bpu_enq_vld, bpu_enq_info, icache_req_rdy, commit_vld, commit_taken,
             redirect_vld, redirect_ftqIdx, redirect_pc,
      output bpu_enq_rdy, icache_req_vld, icache_req_info, icache_req_ftqIdx,
             bp_update_vld, bp_update_info, bpu_redirect_vld, bpu_redirect_pc
   );

endinterface

// File: rtl/ftq_ctrl_ptr_ctrl.sv
// rtl/ftq_ctrl_ptr_ctrl.sv - enq/fetch/commit pointers with wrap bit, full/empty and redirect age math
module ftq_ptr_ctrl #(
   parameter int IDXW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enq_fire,
   input  logic            fetch_fire,
   input  logic            commit_fire,
   input  logic            redirect_vld,
   input  logic [IDXW-1:0] redirect_idx,
   output logic [IDXW-1:0] enq_idx,
   output logic [IDXW-1:0] fetch_idx,
   output logic [IDXW-1:0] fetch_nxt_idx,
   output logic [IDXW-1:0] commit_idx,
   output logic            full,
   output logic            empty,
   output logic            fetch_pending,
   output logic            redirect_in_range
);

   typedef logic [IDXW:0] ptr_t;

   ptr_t enq_ptr, fetch_ptr, commit_ptr;
   ptr_t enq_nxt, fetch_nxt, commit_nxt;
   ptr_t occupancy, redir_age, redir_enq, fetch_adv, fetch_age;

   // Ages are measured from commit so the wrap bit of the new enq follows automatically
   always_comb begin
      occupancy         = enq_ptr - commit_ptr;
      redir_age         = {1'b0, redirect_idx - commit_ptr[IDXW-1:0]};
      redirect_in_range = redir_age < occupancy;
      redir_enq         = commit_ptr + redir_age + ptr_t'(1);
      fetch_adv         = fetch_ptr + ptr_t'(fetch_fire);
      fetch_age         = fetch_adv - commit_ptr;
      commit_nxt        = commit_ptr + ptr_t'(commit_fire);
      enq_nxt           = enq_ptr + ptr_t'(enq_fire);
      fetch_nxt         = fetch_adv;
      if (redirect_vld) begin
         enq_nxt = redir_enq;
         if (fetch_age > redir_age + ptr_t'(1))
            fetch_nxt = redir_enq;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enq_ptr    <= '0;
         fetch_ptr  <= '0;
         commit_ptr <= '0;
      end else begin
         enq_ptr    <= enq_nxt;
         fetch_ptr  <= fetch_nxt;
         commit_ptr <= commit_nxt;
      end
   end

   assign enq_idx       = enq_ptr[IDXW-1:0];
   assign fetch_idx     = fetch_ptr[IDXW-1:0];
   assign fetch_nxt_idx = fetch_nxt[IDXW-1:0];
   assign commit_idx    = commit_ptr[IDXW-1:0];
   assign empty         = enq_ptr == commit_ptr;
   assign full          = (enq_ptr[IDXW-1:0] == commit_ptr[IDXW-1:0]) &&
                          (enq_ptr[IDXW] != commit_ptr[IDXW]);
   assign fetch_pending = fetch_ptr != enq_ptr;

endmodule

// File: rtl/ftq_ctrl.sv
// rtl/ftq_ctrl.sv - fetch target queue controller: BPU enqueue, icache issue, commit update, redirect
// Optional same-cycle issue into an empty queue is enabled by defining FTQ_ISSUE_BYPASS_EN.
module ftq_ctrl
   import ftq_ctrl_pkg::*;
#(
   parameter int FTQ_SIZE = FTQ_SIZE_DEFAULT
) (
   input logic       clk,
   input logic       rst,
   ftq_ctrl_if.slave io
);

   localparam int IDXW = $clog2(FTQ_SIZE);

   ftq_state_t      state, state_nxt;
   ftqInfo_t        entries [FTQ_SIZE];
   ftqInfo_t        head;
   BPupdateInfo_t   update_nxt;
   ftq2icacheInfo_t req_info_q;
   logic [IDXW-1:0] enq_idx, fetch_idx, fetch_nxt_idx, commit_idx;
   logic            full, empty, fetch_pending, redirect_in_range;
   logic            enq_fire, fetch_fire, commit_fire;

   ftq_ptr_ctrl #(.IDXW(IDXW)) u_ptr (
      .clk              (clk),
      .rst              (rst),
      .enq_fire         (enq_fire),
      .fetch_fire       (fetch_fire),
      .commit_fire      (commit_fire),
      .redirect_vld     (io.redirect_vld),
      .redirect_idx     (io.redirect_ftqIdx),
      .enq_idx          (enq_idx),
      .fetch_idx        (fetch_idx),
      .fetch_nxt_idx    (fetch_nxt_idx),
      .commit_idx       (commit_idx),
      .full             (full),
      .empty            (empty),
      .fetch_pending    (fetch_pending),
      .redirect_in_range(redirect_in_range)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // A redirect arriving while already flushing starts a fresh one-cycle flush
   always_comb begin
      state_nxt            = state;
      io.bpu_enq_rdy       = 1'b0;
      io.icache_req_vld    = 1'b0;
      io.icache_req_info   = req_info_q;
      io.icache_req_ftqIdx = fetch_idx;
      case (state)
         RUN: begin
            if (io.redirect_vld)
               state_nxt = FLUSH;
            io.bpu_enq_rdy    = !full && !io.redirect_vld && !rst;
            io.icache_req_vld = fetch_pending;
`ifdef FTQ_ISSUE_BYPASS_EN
            if (empty && io.bpu_enq_vld && io.bpu_enq_rdy) begin
               io.icache_req_vld    = 1'b1;
               io.icache_req_info   = toIcacheReq(io.bpu_enq_info.startAddr, io.bpu_enq_info.endAddr);
               io.icache_req_ftqIdx = enq_idx;
            end
`endif
         end
         FLUSH:   state_nxt = io.redirect_vld ? FLUSH : RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign enq_fire            = io.bpu_enq_vld && io.bpu_enq_rdy;
   assign fetch_fire          = io.icache_req_vld && io.icache_req_rdy;
   assign commit_fire         = io.commit_vld && !empty;
   assign io.bpu_redirect_vld = state == FLUSH;

   always_comb begin
      head                          = entries[commit_idx];
      update_nxt.startAddr          = head.startAddr;
      update_nxt.ftb_update         = head.ftbInfo;
      update_nxt.ftb_update.counter = head.ftbInfo.hit_on_ftb ?
                                      satCounterUpdate(head.ftbInfo.counter, io.commit_taken) :
                                      (io.commit_taken ? 2'b10 : 2'b01);
   end

   // Payload register tracks the entry the fetch pointer will address next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FTQ_SIZE; i++)
            entries[i] <= '0;
         req_info_q         <= '0;
         io.bp_update_vld   <= 1'b0;
         io.bp_update_info  <= '0;
         io.bpu_redirect_pc <= '0;
      end else begin
         if (enq_fire)
            entries[enq_idx] <= io.bpu_enq_info;
         if (enq_fire && enq_idx == fetch_nxt_idx)
            req_info_q <= toIcacheReq(io.bpu_enq_info.startAddr, io.bpu_enq_info.endAddr);
         else
            req_info_q <= toIcacheReq(entries[fetch_nxt_idx].startAddr, entries[fetch_nxt_idx].endAddr);
         io.bp_update_vld <= commit_fire;
         if (commit_fire)
            io.bp_update_info <= update_nxt;
         if (io.redirect_vld)
            io.bpu_redirect_pc <= io.redirect_pc;
      end
   end

   a_commit_not_empty: assert property (@(posedge clk) disable iff (rst) io.commit_vld |-> !empty);
   a_redirect_in_range: assert property (@(posedge clk) disable iff (rst) io.redirect_vld |-> redirect_in_range);

endmodule

// File: tb/tb_ftq_ctrl.sv
// tb/tb_ftq_ctrl.sv - scoreboard bench for ftq_ctrl with directed vectors
module tb_ftq_ctrl;
   import ftq_ctrl_pkg::*;

   typedef struct packed {
      ftq2icacheInfo_t info;
      ftqIdx_t         idx;
   } req_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   req_exp_t        exp_req_q [$];
   BPupdateInfo_t   exp_upd_q [$];
   logic [XLEN-1:0] exp_pc_q  [$];
   req_exp_t        mon_req;
   BPupdateInfo_t   mon_upd;
   logic [XLEN-1:0] mon_pc;

   logic [31:0] b_start [8] = '{32'h2000, 32'h2040, 32'h2080, 32'h20C0,
                                32'h2100, 32'h2140, 32'h2180, 32'h13FF8};
   logic [12:0] b_end   [8] = '{13'h1002, 13'h1023, 13'h1044, 13'h1065,
                                13'h1086, 13'h10A7, 13'h10C8, 13'h0004};
   logic [4:0]  b_size  [8] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd8};
   logic        b_hit   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [1:0]  b_cnt   [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
   logic        b_taken [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [1:0]  b_expc  [8] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};

   logic [31:0] a_start [5] = '{32'h5000, 32'h5010, 32'h5020, 32'h5030, 32'h5040};
   logic [12:0] a_end   [5] = '{13'h0801, 13'h080A, 13'h0813, 13'h081C, 13'h0825};
   logic [4:0]  a_size  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};

   always #5 clk = ~clk;

   ftq_ctrl_if bus ();

   ftq_ctrl dut (
      .clk(clk),
      .rst(rst),
      .io (bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: got an output with nothing expected", name);
   endtask

   function automatic ftqInfo_t mk(input logic [31:0] s, input logic [12:0] e,
                                   input logic hit, input logic [1:0] cnt, input logic [31:0] tgt);
      ftqInfo_t r;
      r.startAddr          = s;
      r.endAddr            = e;
      r.ftbInfo.hit_on_ftb = hit;
      r.ftbInfo.counter    = cnt;
      r.ftbInfo.target     = tgt;
      return r;
   endfunction

   function automatic BPupdateInfo_t mk_upd(input logic [31:0] s, input logic hit,
                                            input logic [1:0] cnt, input logic [31:0] tgt);
      BPupdateInfo_t r;
      r.startAddr             = s;
      r.ftb_update.hit_on_ftb = hit;
      r.ftb_update.counter    = cnt;
      r.ftb_update.target     = tgt;
      return r;
   endfunction

   function automatic req_exp_t mk_req(input logic [31:0] s, input logic [4:0] sz, input ftqIdx_t idx);
      req_exp_t r;
      r.info.startAddr       = s;
      r.info.fetchBlock_size = sz;
      r.idx                  = idx;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.icache_req_vld && bus.icache_req_rdy) begin
            if (exp_req_q.size() == 0)
               unexpected("icache_req");
            else begin
               mon_req = exp_req_q.pop_front();
               check("icache_req", {bus.icache_req_info, bus.icache_req_ftqIdx}, mon_req);
            end
         end
         if (bus.bp_update_vld) begin
            if (exp_upd_q.size() == 0)
               unexpected("bp_update");
            else begin
               mon_upd = exp_upd_q.pop_front();
               check("bp_update", bus.bp_update_info, mon_upd);
            end
         end
         if (bus.bpu_redirect_vld) begin
            if (exp_pc_q.size() == 0)
               unexpected("bpu_redirect");
            else begin
               mon_pc = exp_pc_q.pop_front();
               check("bpu_redirect_pc", bus.bpu_redirect_pc, mon_pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bpu_enq_vld     = 1'b0;
      bus.bpu_enq_info    = '0;
      bus.icache_req_rdy  = 1'b0;
      bus.commit_vld      = 1'b0;
      bus.commit_taken    = 1'b0;
      bus.redirect_vld    = 1'b0;
      bus.redirect_ftqIdx = '0;
      bus.redirect_pc     = '0;

      // reset and idle
      tick();
      tick();
      check("reset_enq_rdy", bus.bpu_enq_rdy, 1'b0);
      check("reset_icache_vld", bus.icache_req_vld, 1'b0);
      rst = 1'b0;
      tick();
      check("idle_enq_rdy", bus.bpu_enq_rdy, 1'b1);
      check("idle_valids", {bus.icache_req_vld, bus.bp_update_vld, bus.bpu_redirect_vld}, 3'b000);
      check("idle_payloads", {bus.bp_update_info, bus.bpu_redirect_pc, bus.icache_req_info}, '0);

      // single block issued one cycle after enqueue
      bus.icache_req_rdy = 1'b1;
      bus.bpu_enq_vld    = 1'b1;
      bus.bpu_enq_info   = mk(32'h1000, 13'h0808, 1'b1, 2'd2, 32'h9000);
      exp_req_q.push_back(mk_req(32'h1000, 5'd8, 3'd0));
      tick();
      bus.bpu_enq_vld = 1'b0;
`ifndef FTQ_ISSUE_BYPASS_EN
      #1 check("t1_issue_next_cycle", bus.icache_req_vld, 1'b1);
`endif
      tick();
      check("t1_issue_done", bus.icache_req_vld, 1'b0);
      bus.commit_vld   = 1'b1;
      bus.commit_taken = 1'b1;
      exp_upd_q.push_back(mk_upd(32'h1000, 1'b1, 2'd3, 32'h9000));
      tick();
      bus.commit_vld = 1'b0;
      tick();

      // fill the queue with the icache stalled
      bus.icache_req_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.bpu_enq_vld  = 1'b1;
         bus.bpu_enq_info = mk(b_start[i], b_end[i], b_hit[i], b_cnt[i], 32'hA000 + i);
         #1 check("t2_rdy_fill", bus.bpu_enq_rdy, 1'b1);
         exp_req_q.push_back(mk_req(b_start[i], b_size[i], 3'((1 + i) % 8)));
         tick();
      end
      bus.bpu_enq_info = mk(32'hDEAD0, 13'h0, 1'b0, 2'd0, 32'h0);
      #1 check("t2_full_rdy", bus.bpu_enq_rdy, 1'b0);
      bus.bpu_enq_vld = 1'b0;

      // stalled request holds its payload, then advances by exactly one
      for (int k = 0; k < 3; k++) begin
         check("t3_stall_vld", bus.icache_req_vld, 1'b1);
         check("t3_stall_payload", {bus.icache_req_info, bus.icache_req_ftqIdx},
               mk_req(32'h2000, 5'd2, 3'd1));
         tick();
      end
      bus.icache_req_rdy = 1'b1;
      tick();
      bus.icache_req_rdy = 1'b0;
      #1 check("t3_advance", {bus.icache_req_info, bus.icache_req_ftqIdx},
               mk_req(32'h2040, 5'd3, 3'd2));

      // commit on a full queue: rdy follows one cycle later
      bus.commit_vld   = 1'b1;
      bus.commit_taken = b_taken[0];
      exp_upd_q.push_back(mk_upd(b_start[0], b_hit[0], b_expc[0], 32'hA000));
      #1 check("t2_full_commit_rdy", bus.bpu_enq_rdy, 1'b0);
      tick();
      bus.commit_vld = 1'b0;
      #1 check("t2_rdy_after_commit", bus.bpu_enq_rdy, 1'b1);

      // drain fetch, then commit with counter update cases
      bus.icache_req_rdy = 1'b1;
      repeat (7) tick();
      bus.icache_req_rdy = 1'b0;
      check("t3_drained", bus.icache_req_vld, 1'b0);
      for (int i = 1; i < 8; i++) begin
         bus.commit_vld   = 1'b1;
         bus.commit_taken = b_taken[i];
         exp_upd_q.push_back(mk_upd(b_start[i], b_hit[i], b_expc[i], 32'hA000 + i));
         tick();
      end
      bus.commit_vld = 1'b0;
      tick();
      tick();

      // redirect squashes younger entries
      rst = 1'b1;
      tick();
      check("t5_reset_rdy", bus.bpu_enq_rdy, 1'b0);
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         bus.bpu_enq_vld  = 1'b1;
         bus.bpu_enq_info = mk(a_start[j], a_end[j], 1'b1, 2'd1, 32'hB000 + j);
         if (j < 3)
            exp_req_q.push_back(mk_req(a_start[j], a_size[j], 3'(j)));
         tick();
      end
      bus.bpu_enq_info    = mk(32'hDEAD0, 13'h0, 1'b0, 2'd0, 32'h0);
      bus.redirect_vld    = 1'b1;
      bus.redirect_ftqIdx = 3'd2;
      bus.redirect_pc     = 32'h2000;
      exp_pc_q.push_back(32'h2000);
      #1 check("t5_enq_blocked", bus.bpu_enq_rdy, 1'b0);
      tick();
      bus.redirect_vld = 1'b0;
      bus.bpu_enq_vld  = 1'b0;
      #1 check("t5_flush_no_req", bus.icache_req_vld, 1'b0);
      check("t5_flush_rdy", bus.bpu_enq_rdy, 1'b0);
      tick();
      check("t5_flush_one_cycle", {bus.bpu_redirect_vld, bus.bpu_enq_rdy}, 2'b01);
      bus.bpu_enq_vld  = 1'b1;
      bus.bpu_enq_info = mk(32'h2000, 13'h1006, 1'b0, 2'd0, 32'hC000);
      exp_req_q.push_back(mk_req(32'h2000, 5'd6, 3'd3));
      tick();
      bus.bpu_enq_vld    = 1'b0;
      bus.icache_req_rdy = 1'b1;
      repeat (4) tick();
      bus.icache_req_rdy = 1'b0;
      check("t5_drained", bus.icache_req_vld, 1'b0);
      for (int j = 0; j < 4; j++) begin
         bus.commit_vld   = 1'b1;
         bus.commit_taken = (j < 3);
         if (j < 3)
            exp_upd_q.push_back(mk_upd(a_start[j], 1'b1, 2'd2, 32'hB000 + j));
         else
            exp_upd_q.push_back(mk_upd(32'h2000, 1'b0, 2'b01, 32'hC000));
         tick();
      end
      bus.commit_vld = 1'b0;
      tick();

`ifdef FTQ_ISSUE_BYPASS_EN
      // empty queue issues the enqueued block in the same cycle
      bus.icache_req_rdy = 1'b1;
      bus.bpu_enq_vld    = 1'b1;
      bus.bpu_enq_info   = mk(32'h3000, 13'h1804, 1'b0, 2'd0, 32'hD000);
      exp_req_q.push_back(mk_req(32'h3000, 5'd4, 3'd4));
      #1 check("t6_bypass_same_cycle", bus.icache_req_vld, 1'b1);
      tick();
      bus.bpu_enq_vld = 1'b0;
      #1 check("t6_empty_fetched", bus.icache_req_vld, 1'b0);
      bus.icache_req_rdy = 1'b0;
`endif

      tick();
      tick();
      check("left_icache_req", exp_req_q.size(), 0);
      check("left_bp_update", exp_upd_q.size(), 0);
      check("left_bpu_redirect", exp_pc_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
